alu_master: RTL and testbench
=============================

# alu_master

Initiator for the multi-cycle 32-bit ALU valid/ready protocol: accepts operation commands from an upstream client, buffers them in a small FIFO, and issues them to the ALU one at a time. Each ALU issue is a one-cycle `alu_valid` pulse with operands held stable until the result arrives. The block captures the 64-bit result on the ALU's single-cycle `alu_ready` pulse and holds it for a downstream consumer under a valid/ready handshake. It sits between the CPU-side command path and the ALU responder.

## Interface
- `CMD_DEPTH`, default 2: command FIFO depth; power of 2, ≥2.
- `TIMEOUT`, default 64: maximum number of WAIT cycles before a timeout fires; used only with the macro.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  upstream command present.
- `cmd_ready`  out  1  FIFO not full.
- `cmd_mode`  in  2  0 mulu, 1 divu, 2 and, 3 or.
- `cmd_a`, `cmd_b`  in  32  operands.
- `alu_valid`  out  1  one-cycle issue pulse.
- `alu_mode`  out  2  held from ISSUE until the result is captured.
- `alu_in_A`, `alu_in_B`  out  32  held like `alu_mode`.
- `alu_ready`  in  1  ALU result strobe, one cycle.
- `alu_out`  in  64  ALU result; valid only while `alu_ready` is high.
- `rsp_valid`  out  1  response held for the consumer.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  64  captured `alu_out`, unchanged.
- `rsp_mode`  out  2  mode of the operation that produced the response.
- `rsp_timeout`  out  1  response produced by timeout; `rsp_data` = 0.
- `err`  out  1  sticky timeout flag.

## Operation
- Push into the FIFO on `cmd_valid && cmd_ready`. `cmd_ready = !full`; there is no bypass, so a push while full is not accepted.
- FSM states:
  - IDLE → ISSUE when the FIFO is non-empty and `err` = 0.
  - ISSUE: `alu_valid` = 1 for exactly one cycle. The FIFO head is popped into the `alu_*` registers on entry to ISSUE. Then → WAIT.
  - WAIT: `alu_valid` = 0. When `alu_ready` = 1, latch `alu_out` into `rsp_data` → RESP.
  - RESP: `rsp_valid` = 1. On `rsp_ready` → IDLE.
- `alu_valid` is never high outside ISSUE. The ALU reloads its operand latch on any valid, so a stray pulse corrupts an in-flight operation.
- `alu_mode`, `alu_in_A` and `alu_in_B` stay stable through the whole `alu_ready` cycle, because the ALU muxes `out` by mode in that cycle.
- `alu_ready` is ignored outside WAIT.
- Simultaneous push and pop (pop on entry to ISSUE) while not full: count is unchanged, and the pointers wrap modulo `CMD_DEPTH`.
- FIFO empty in IDLE: stay in IDLE, all ALU outputs hold their last values.
- Reset mid-operation: all state is cleared immediately and queued commands are lost. The ALU is reset by the same `rst_n`.
- Reset values:
  - `cmd_ready` = 1.
  - `alu_valid`, `rsp_valid`, `rsp_timeout`, `err` = 0.
  - `alu_mode`, `alu_in_*`, `rsp_data`, `rsp_mode` = 0.
  - FSM in IDLE, FIFO empty.

## Timing
- Command accepted at edge E0 → ISSUE at E1 → `alu_valid` high E1–E2.
- and/or: `alu_ready` high E3–E4, RESP at E4, `rsp_valid` high after E4.
- mulu/divu: 32 ALU compute cycles, `alu_ready` high E34–E35, `rsp_valid` high after E35.
- Back-to-back: the next `alu_valid` comes no earlier than one cycle after RESP is left. It never coincides with `alu_ready`.
- `rsp_valid` holds, with `rsp_data` stable, until `rsp_ready`. The FIFO keeps accepting commands meanwhile.

## Configuration
- `ALU_MASTER_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs while in WAIT; it is cleared when WAIT is entered.
  - If the counter reaches `TIMEOUT` with no `alu_ready`, go to RESP with `rsp_timeout` = 1 and `rsp_data` = 0, and set `err`.
  - While `err` is set, no further issues occur; this is cleared only by reset.
- `ALU_MASTER_TIMEOUT_EN` undefined:
  - WAIT waits indefinitely; no timeout counter exists.
  - `rsp_timeout` and `err` are tied to 0.

## Structure
- Shared package `alu_pkg`:
  - Mode encodings: `MODE_MULU`, `MODE_DIVU`, `MODE_AND`, `MODE_OR`.
  - FSM state enum for IDLE, ISSUE, WAIT, RESP.
  - Result width constant of 64.
- One sub-module, `alu_cmd_fifo`: parameterised `CMD_DEPTH`, 34+32 bits wide (mode+A+B), with full/empty flags. Count width is $clog2(`CMD_DEPTH`)+1.
- The FSM, result register and timeout counter are in `alu_master`.

## Test plan
- and `0xF0F0F0F0`, `0x0FF00FF0` against the real ALU → `rsp_data` = 64'h0000_0000_00F0_00F0, `rsp_valid` 4 edges after accept.
- mulu 3×5, then `0xFFFFFFFF`×`0xFFFFFFFF` queued back-to-back → 64'd15, then 64'hFFFF_FFFE_0000_0001, in order. Exactly one `alu_valid` pulse per op.
- divu 100/7 → `rsp_data` = 64'h0000_0002_0000_000E; `rsp_ready` held low 10 cycles → `rsp_data` stable, third command accepted, then FIFO full with `cmd_ready` = 0.
- Stub ALU never asserts ready with macro defined, `TIMEOUT` = 64 → RESP after 64 WAIT cycles, `rsp_timeout` = 1, `err` = 1, no further `alu_valid`.
- `rst_n` pulsed low during the mulu WAIT phase → all outputs return to reset values, FIFO empty. A fresh or 1,2 → 64'h0000_0000_0000_0003.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU master: mode encodings, FSM states and the
// queued command layout.
package alu_pkg;

  localparam int RES_W = 64;
  localparam int OP_W  = 32;

  typedef enum logic [1:0] {
    MODE_MULU = 2'd0,
    MODE_DIVU = 2'd1,
    MODE_AND  = 2'd2,
    MODE_OR   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // One queued command: mode plus both operands (2+32+32 bits).
  typedef struct packed {
    mode_e           mode;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } cmd_t;

endpackage

// File: rtl/alu_master_if.sv
// Command, ALU and response signal bundle for alu_master; the master modport
// is the block's view, the slave modport is the client/ALU/consumer side.
interface alu_master_if
  import alu_pkg::*;
;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [OP_W-1:0]  cmd_a;
  logic [OP_W-1:0]  cmd_b;

  logic             alu_valid;
  logic [1:0]       alu_mode;
  logic [OP_W-1:0]  alu_in_A;
  logic [OP_W-1:0]  alu_in_B;
  logic             alu_ready;
  logic [RES_W-1:0] alu_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [RES_W-1:0] rsp_data;
  logic [1:0]       rsp_mode;
  logic             rsp_timeout;
  logic             err;

  modport master (
    input  cmd_valid, cmd_mode, cmd_a, cmd_b, alu_ready, alu_out, rsp_ready,
    output cmd_ready, alu_valid, alu_mode, alu_in_A, alu_in_B,
           rsp_valid, rsp_data, rsp_mode, rsp_timeout, err
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_a, cmd_b, alu_ready, alu_out, rsp_ready,
    input  cmd_ready, alu_valid, alu_mode, alu_in_A, alu_in_B,
           rsp_valid, rsp_data, rsp_mode, rsp_timeout, err
  );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Small command FIFO for alu_master; CMD_DEPTH must be a power of two so the
// read/write pointers wrap naturally.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int CMD_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  cmd_t wr_data,
  output cmd_t rd_data,
  output logic full,
  output logic empty
);

  localparam int PTR_W = $clog2(CMD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  cmd_t             mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(CMD_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an empty count makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_master.sv
// Queues client commands and issues them one at a time to the multi-cycle ALU,
// holding each result for the consumer. Define ALU_MASTER_TIMEOUT_EN for the WAIT timeout.
module alu_master
  import alu_pkg::*;
#(
  parameter int CMD_DEPTH = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic clk,
  input  logic rst_n,
  alu_master_if.master bus
);

  state_e           state;
  cmd_t             cmd_in;
  cmd_t             fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             issue_pop;
  logic             timeout_hit;

  logic             alu_valid_q;
  mode_e            alu_mode_q;
  logic [OP_W-1:0]  alu_a_q;
  logic [OP_W-1:0]  alu_b_q;
  logic             rsp_valid_q;
  logic [RES_W-1:0] rsp_data_q;
  mode_e            rsp_mode_q;
  logic             rsp_timeout_q;
  logic             err_q;

  assign cmd_in    = '{mode: mode_e'(bus.cmd_mode), a: bus.cmd_a, b: bus.cmd_b};
  assign issue_pop = (state == ST_IDLE) && !fifo_empty && !err_q;

  alu_cmd_fifo #(
    .CMD_DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (bus.cmd_valid),
    .pop     (issue_pop),
    .wr_data (cmd_in),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef ALU_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] wait_cnt;

  // Counts WAIT cycles; the last permitted cycle is TIMEOUT-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 wait_cnt <= '0;
    else if (state == ST_ISSUE) wait_cnt <= '0;
    else if (state == ST_WAIT)  wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout_hit = (state == ST_WAIT) && (wait_cnt == TO_W'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      alu_valid_q   <= 1'b0;
      alu_mode_q    <= MODE_MULU;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_mode_q    <= MODE_MULU;
      rsp_timeout_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue_pop) begin
            alu_valid_q <= 1'b1;
            alu_mode_q  <= fifo_head.mode;
            alu_a_q     <= fifo_head.a;
            alu_b_q     <= fifo_head.b;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          alu_valid_q <= 1'b0;
          state       <= ST_WAIT;
        end
        // Operands stay put through the ready cycle; the ALU muxes its output by mode then.
        ST_WAIT: begin
          if (bus.alu_ready) begin
            rsp_data_q  <= bus.alu_out;
            rsp_mode_q  <= alu_mode_q;
            rsp_valid_q <= 1'b1;
            state       <= ST_RESP;
          end else if (timeout_hit) begin
            rsp_data_q    <= '0;
            rsp_mode_q    <= alu_mode_q;
            rsp_valid_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            err_q         <= 1'b1;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready   = !fifo_full;
  assign bus.alu_valid   = alu_valid_q;
  assign bus.alu_mode    = alu_mode_q;
  assign bus.alu_in_A    = alu_a_q;
  assign bus.alu_in_B    = alu_b_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_mode    = rsp_mode_q;
  assign bus.rsp_timeout = rsp_timeout_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_alu_master.sv
// Directed, scoreboard-checked bench for alu_master with a behavioural
// multi-cycle ALU (1 cycle for and/or, 32 cycles for mulu/divu).
module tb_alu_master;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  mode;
    logic        to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  alu_master_if bus ();

  alu_master #(
    .CMD_DEPTH (2),
    .TIMEOUT   (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  int          valid_pulses = 0;
  int          overlap  = 0;
  int          hold_bad = 0;

  logic        alu_stub;
  logic        stray_ready;
  logic        m_ready;
  int          m_cnt;
  logic [31:0] lat_a, lat_b;
  logic [1:0]  lat_mode;
  logic [63:0] m_out;

  // Behavioural ALU: latches operands on any valid, strobes ready after its latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready  <= 1'b0;
      m_cnt    <= 0;
      lat_a    <= '0;
      lat_b    <= '0;
      lat_mode <= '0;
    end else begin
      m_ready <= 1'b0;
      if (bus.alu_valid && !alu_stub) begin
        lat_a    <= bus.alu_in_A;
        lat_b    <= bus.alu_in_B;
        lat_mode <= bus.alu_mode;
        m_cnt    <= bus.alu_mode[1] ? 1 : 32;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_ready <= 1'b1;
      end
    end
  end

  always_comb begin
    m_out = 64'hDEAD_BEEF_DEAD_BEEF;
    if (m_ready) begin
      case (bus.alu_mode)
        2'd0:    m_out = {32'd0, lat_a} * {32'd0, lat_b};
        2'd1:    m_out = {lat_a % lat_b, lat_a / lat_b};
        2'd2:    m_out = {32'd0, lat_a & lat_b};
        default: m_out = {32'd0, lat_a | lat_b};
      endcase
    end
  end

  assign bus.alu_out   = m_out;
  assign bus.alu_ready = m_ready | stray_ready;

  always @(negedge clk) begin
    if (bus.alu_valid === 1'b1) valid_pulses++;
    if (bus.alu_valid === 1'b1 && bus.alu_ready === 1'b1) overlap++;
    if (m_ready && (bus.alu_in_A !== lat_a || bus.alu_in_B !== lat_b ||
                    bus.alu_mode !== lat_mode)) hold_bad++;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [1:0] mode, input logic [31:0] a, input logic [31:0] b,
                                input logic [63:0] exp_data, input logic exp_to);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_output("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = mode;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(posedge clk);
    e.data = exp_data;
    e.mode = mode;
    e.to   = exp_to;
    sb.push_back(e);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Waits for a response and compares it with the scoreboard head; exp_lat < 0 skips latency.
  task automatic wait_rsp(input string tag, input int exp_lat);
    int   n = 0;
    exp_t e;
    while (bus.rsp_valid !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_valid"}, 64'(bus.rsp_valid), 64'd1);
    if (bus.rsp_valid === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      check_output({tag, "_data"}, bus.rsp_data, e.data);
      check_output({tag, "_mode"}, 64'(bus.rsp_mode), 64'(e.mode));
      check_output({tag, "_timeout"}, 64'(bus.rsp_timeout), 64'(e.to));
      if (exp_lat >= 0) check_output({tag, "_latency"}, 64'(n), 64'(exp_lat));
    end
  endtask

  task automatic consume();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    int          p0;
    int          unstable;
    logic [63:0] snap;

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;
    alu_stub      = 1'b0;
    stray_ready   = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    check_output("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    check_output("rst_alu_valid", 64'(bus.alu_valid), 64'd0);
    check_output("rst_alu_mode", 64'(bus.alu_mode), 64'd0);
    check_output("rst_alu_in_A", 64'(bus.alu_in_A), 64'd0);
    check_output("rst_alu_in_B", 64'(bus.alu_in_B), 64'd0);
    check_output("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_output("rst_rsp_data", bus.rsp_data, 64'd0);
    check_output("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    check_output("rst_err", 64'(bus.err), 64'd0);
    rst_n = 1'b1;

    $display("[TB] and with 4-edge latency");
    apply_stimulus(2'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0000_0000_00F0_00F0, 1'b0);
    wait_rsp("and", 4);
    consume();

    $display("[TB] idle hold and stray alu_ready");
    p0 = valid_pulses;
    @(negedge clk);
    stray_ready = 1'b1;
    @(negedge clk);
    stray_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_output("stray_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check_output("stray_rsp_data", bus.rsp_data, 64'h0000_0000_00F0_00F0);
    check_output("idle_hold_A", 64'(bus.alu_in_A), 64'hF0F0_F0F0);
    check_output("idle_no_issue", 64'(valid_pulses - p0), 64'd0);

    $display("[TB] back-to-back mulu");
    p0 = valid_pulses;
    apply_stimulus(2'd0, 32'd3, 32'd5, 64'd15, 1'b0);
    apply_stimulus(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0);
    wait_rsp("mul1", -1);
    consume();
    wait_rsp("mul2", -1);
    consume();
    check_output("mul_pulses", 64'(valid_pulses - p0), 64'd2);

    $display("[TB] divu with stalled consumer");
    apply_stimulus(2'd1, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b0);
    wait_rsp("divu", 35);
    snap = bus.rsp_data;
    apply_stimulus(2'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 64'h0000_0000_0F00_0F00, 1'b0);
    apply_stimulus(2'd3, 32'h1234_0000, 32'h0000_5678, 64'h0000_0000_1234_5678, 1'b0);
    check_output("full_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    unstable = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_data !== snap || bus.rsp_valid !== 1'b1) unstable++;
    end
    check_output("stall_stable", 64'(unstable), 64'd0);
    consume();
    wait_rsp("queued_and", -1);
    consume();
    wait_rsp("queued_or", -1);
    consume();

    $display("[TB] reset during mulu WAIT");
    apply_stimulus(2'd0, 32'd7, 32'd9, 64'd63, 1'b0);
    repeat (10) @(negedge clk);
    apply_stimulus(2'd2, 32'd1, 32'd1, 64'd1, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_alu_valid", 64'(bus.alu_valid), 64'd0);
    check_output("mid_rst_alu_in_A", 64'(bus.alu_in_A), 64'd0);
    check_output("mid_rst_alu_in_B", 64'(bus.alu_in_B), 64'd0);
    check_output("mid_rst_alu_mode", 64'(bus.alu_mode), 64'd0);
    check_output("mid_rst_rsp_data", bus.rsp_data, 64'd0);
    check_output("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    p0 = valid_pulses;
    repeat (6) @(negedge clk);
    check_output("post_rst_fifo_empty", 64'(valid_pulses - p0), 64'd0);
    apply_stimulus(2'd3, 32'd1, 32'd2, 64'h0000_0000_0000_0003, 1'b0);
    wait_rsp("or_after_rst", 4);
    consume();

`ifdef ALU_MASTER_TIMEOUT_EN
    $display("[TB] timeout with silent ALU");
    alu_stub = 1'b1;
    apply_stimulus(2'd2, 32'd1, 32'd1, 64'd0, 1'b1);
    wait_rsp("timeout", 66);
    check_output("timeout_err", 64'(bus.err), 64'd1);
    consume();
    p0 = valid_pulses;
    apply_stimulus(2'd3, 32'd1, 32'd1, 64'd0, 1'b0);
    repeat (20) @(negedge clk);
    check_output("err_blocks_issue", 64'(valid_pulses - p0), 64'd0);
    check_output("err_sticky", 64'(bus.err), 64'd1);
`endif

    check_output("valid_ready_overlap", 64'(overlap), 64'd0);
    check_output("operand_hold", 64'(hold_bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
